// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: in-order writeback vs. a FIFO-buffered auxiliary writer,
// with a starvation guard that stalls writeback and a pending-write hazard check for decode.
module rf_write_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 2,
  parameter int MAX_WAIT   = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              aux_valid,
  output logic              aux_ready,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [DATA_W-1:0] aux_data,
  output logic              stall_wb,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_data,
  output logic              pending,
  input  logic [ADDR_W-1:0] chk_addr,
  output logic              chk_hit
);
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  logic [FIFO_DEPTH-1:0][ADDR_W-1:0] fifo_addr_q;
  logic [FIFO_DEPTH-1:0][DATA_W-1:0] fifo_data_q;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0] rf_data_q, rf_data_d;

  logic full, starve, push, pop, grant_wb;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic [FIFO_DEPTH-1:0] hit_vec;

  assign full      = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign pending   = (cnt_q != '0);
  assign starve    = pending && (wait_q == WAIT_W'(MAX_WAIT));
  assign aux_ready = !full;
  assign stall_wb  = starve;
  assign push      = aux_valid && !full;
  assign pop       = starve || (!wb_we && pending);
  assign grant_wb  = wb_we && !starve;
  assign head_addr = fifo_addr_q[rd_ptr_q];
  assign head_data = fifo_data_q[rd_ptr_q];

  assign cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);

  always_comb begin
    wait_d = wait_q;
    if (!pending || pop)                  wait_d = '0;
    else if (wait_q != WAIT_W'(MAX_WAIT)) wait_d = wait_q + WAIT_W'(1);
  end

  // Address-0 writes are consumed (granted/popped) but never reach the register file.
  always_comb begin
    rf_we_d   = 1'b0;
    rf_addr_d = rf_addr_q;
    rf_data_d = rf_data_q;
    if (pop) begin
      if (head_addr != '0) begin
        rf_we_d   = 1'b1;
        rf_addr_d = head_addr;
        rf_data_d = head_data;
      end
    end else if (grant_wb) begin
      if (wb_addr != '0) begin
        rf_we_d   = 1'b1;
        rf_addr_d = wb_addr;
        rf_data_d = wb_data;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      wait_q    <= '0;
      rf_we_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q     <= cnt_d;
      wait_q    <= wait_d;
      rf_we_q   <= rf_we_d;
      rf_addr_q <= rf_addr_d;
      rf_data_q <= rf_data_d;
    end
  end

  // Storage is qualified by occupancy, so it needs no reset.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= aux_addr;
      fifo_data_q[wr_ptr_q] <= aux_data;
    end
  end

  for (genvar i = 0; i < FIFO_DEPTH; i++) begin : g_hit
    logic [PTR_W-1:0] ofs;
    assign ofs        = PTR_W'(i) - rd_ptr_q;
    assign hit_vec[i] = ({1'b0, ofs} < cnt_q) && (fifo_addr_q[i] == chk_addr);
  end

  assign chk_hit = (chk_addr != '0) &&
                   ((|hit_vec) || (rf_we_q && (rf_addr_q == chk_addr)));

  assign rf_we   = rf_we_q;
  assign rf_addr = rf_addr_q;
  assign rf_data = rf_data_q;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: reset, writeback, aux drain, starvation, full FIFO, addr 0.
module tb_rf_write_arbiter;
  logic        clock = 1'b0;
  logic        reset_n;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        aux_valid;
  logic        aux_ready;
  logic [4:0]  aux_addr;
  logic [31:0] aux_data;
  logic        stall_wb;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        pending;
  logic [4:0]  chk_addr;
  logic        chk_hit;

  int n_checks = 0;
  int n_fail   = 0;

  rf_write_arbiter #(.DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(2), .MAX_WAIT(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .aux_valid(aux_valid), .aux_ready(aux_ready), .aux_addr(aux_addr), .aux_data(aux_data),
    .stall_wb(stall_wb), .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
    .pending(pending), .chk_addr(chk_addr), .chk_hit(chk_hit)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; wb_we = 0; wb_addr = 0; wb_data = 0;
    aux_valid = 0; aux_addr = 0; aux_data = 0; chk_addr = 5'd3;
    #2;
    n_checks++; if (rf_we !== 1'b0)    begin n_fail++; $display("FAIL reset_rf_we got %b want 0", rf_we); end
    n_checks++; if (rf_addr !== 5'd0)  begin n_fail++; $display("FAIL reset_rf_addr got %0d want 0", rf_addr); end
    n_checks++; if (rf_data !== 32'd0) begin n_fail++; $display("FAIL reset_rf_data got %h want 0", rf_data); end
    n_checks++; if (pending !== 1'b0)  begin n_fail++; $display("FAIL reset_pending got %b want 0", pending); end
    n_checks++; if (stall_wb !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", stall_wb); end
    n_checks++; if (aux_ready !== 1'b1) begin n_fail++; $display("FAIL reset_aux_ready got %b want 1", aux_ready); end
    n_checks++; if (chk_hit !== 1'b0)  begin n_fail++; $display("FAIL reset_chk_hit got %b want 0", chk_hit); end
    @(negedge clock); reset_n = 1'b1;
    tick();
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL post_reset_rf_we got %b want 0", rf_we); end
  endtask

  task automatic test_writeback();
    wb_we = 1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
    tick();
    wb_we = 0;
    n_checks++; if (rf_we !== 1'b1)         begin n_fail++; $display("FAIL wb_rf_we got %b want 1", rf_we); end
    n_checks++; if (rf_addr !== 5'd5)       begin n_fail++; $display("FAIL wb_rf_addr got %0d want 5", rf_addr); end
    n_checks++; if (rf_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wb_rf_data got %h want deadbeef", rf_data); end
    n_checks++; if (stall_wb !== 1'b0)      begin n_fail++; $display("FAIL wb_stall got %b want 0", stall_wb); end
    tick();
    n_checks++; if (rf_we !== 1'b0)   begin n_fail++; $display("FAIL wb_idle_rf_we got %b want 0", rf_we); end
    n_checks++; if (rf_addr !== 5'd5) begin n_fail++; $display("FAIL wb_idle_hold got %0d want 5", rf_addr); end
  endtask

  task automatic test_aux_idle();
    aux_valid = 1; aux_addr = 5'd7; aux_data = 32'h00001234; chk_addr = 5'd7;
    tick();
    aux_valid = 0;
    n_checks++; if (pending !== 1'b1) begin n_fail++; $display("FAIL aux_pending got %b want 1", pending); end
    n_checks++; if (chk_hit !== 1'b1) begin n_fail++; $display("FAIL aux_chk_fifo got %b want 1", chk_hit); end
    n_checks++; if (rf_we !== 1'b0)   begin n_fail++; $display("FAIL aux_no_bypass got %b want 0", rf_we); end
    tick();
    n_checks++; if (rf_we !== 1'b1)   begin n_fail++; $display("FAIL aux_rf_we got %b want 1", rf_we); end
    n_checks++; if (rf_addr !== 5'd7) begin n_fail++; $display("FAIL aux_rf_addr got %0d want 7", rf_addr); end
    n_checks++; if (rf_data !== 32'h00001234) begin n_fail++; $display("FAIL aux_rf_data got %h want 00001234", rf_data); end
    n_checks++; if (pending !== 1'b0) begin n_fail++; $display("FAIL aux_drained got %b want 0", pending); end
    n_checks++; if (chk_hit !== 1'b1) begin n_fail++; $display("FAIL aux_chk_outreg got %b want 1", chk_hit); end
    tick();
    n_checks++; if (chk_hit !== 1'b0) begin n_fail++; $display("FAIL aux_chk_clear got %b want 0", chk_hit); end
  endtask

  task automatic test_starvation();
    wb_we = 1; wb_addr = 5'd1; wb_data = 32'h101;
    aux_valid = 1; aux_addr = 5'd9; aux_data = 32'hA5A5A5A5;
    tick();  // edge k: wb 1 granted, aux 9 pushed
    aux_valid = 0;
    for (int i = 1; i <= 4; i++) begin
      n_checks++; if (rf_addr !== 5'(i)) begin n_fail++; $display("FAIL starve_wb_addr[%0d] got %0d want %0d", i, rf_addr, i); end
      n_checks++; if (stall_wb !== 1'b0) begin n_fail++; $display("FAIL starve_early_stall[%0d] got %b want 0", i, stall_wb); end
      wb_addr = 5'(i + 1); wb_data = 32'h100 + 32'(i + 1);
      tick();  // edges k+1..k+4
    end
    n_checks++; if (rf_addr !== 5'd5)  begin n_fail++; $display("FAIL starve_wb5 got %0d want 5", rf_addr); end
    n_checks++; if (stall_wb !== 1'b1) begin n_fail++; $display("FAIL starve_stall got %b want 1", stall_wb); end
    wb_addr = 5'd6; wb_data = 32'h106;
    tick();  // edge k+5: aux pop
    n_checks++; if (rf_addr !== 5'd9)  begin n_fail++; $display("FAIL starve_pop_addr got %0d want 9", rf_addr); end
    n_checks++; if (rf_data !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL starve_pop_data got %h want a5a5a5a5", rf_data); end
    n_checks++; if (stall_wb !== 1'b0) begin n_fail++; $display("FAIL starve_release got %b want 0", stall_wb); end
    tick();  // edge k+6: held writeback
    n_checks++; if (rf_addr !== 5'd6)    begin n_fail++; $display("FAIL starve_held_addr got %0d want 6", rf_addr); end
    n_checks++; if (rf_data !== 32'h106) begin n_fail++; $display("FAIL starve_held_data got %h want 106", rf_data); end
    wb_we = 0;
    tick();
  endtask

  task automatic test_full();
    wb_we = 1; wb_addr = 5'd10; wb_data = 32'hB0;
    aux_valid = 1; aux_addr = 5'd11; aux_data = 32'hA1;
    tick();  // k: push A
    n_checks++; if (aux_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready1 got %b want 1", aux_ready); end
    aux_addr = 5'd12; aux_data = 32'hA2;
    tick();  // k+1: push B
    aux_addr = 5'd13; aux_data = 32'hA3; chk_addr = 5'd12;
    #1;
    n_checks++; if (aux_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready0 got %b want 0", aux_ready); end
    n_checks++; if (chk_hit !== 1'b1)   begin n_fail++; $display("FAIL full_chk_b got %b want 1", chk_hit); end
    tick(); tick();  // k+2, k+3
    n_checks++; if (aux_ready !== 1'b0) begin n_fail++; $display("FAIL full_held got %b want 0", aux_ready); end
    n_checks++; if (stall_wb !== 1'b0)  begin n_fail++; $display("FAIL full_stall_early got %b want 0", stall_wb); end
    tick();  // k+4
    n_checks++; if (stall_wb !== 1'b1)  begin n_fail++; $display("FAIL full_stall got %b want 1", stall_wb); end
    tick();  // k+5: pop A
    n_checks++; if (rf_addr !== 5'd11)  begin n_fail++; $display("FAIL full_pop_a got %0d want 11", rf_addr); end
    n_checks++; if (aux_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_again got %b want 1", aux_ready); end
    tick();  // k+6: push C, wb granted
    n_checks++; if (rf_addr !== 5'd10)  begin n_fail++; $display("FAIL full_wb got %0d want 10", rf_addr); end
    n_checks++; if (aux_ready !== 1'b0) begin n_fail++; $display("FAIL full_c_taken got %b want 0", aux_ready); end
    aux_valid = 0; wb_we = 0;
    tick();
    n_checks++; if (rf_addr !== 5'd12)  begin n_fail++; $display("FAIL full_pop_b got %0d want 12", rf_addr); end
    tick();
    n_checks++; if (rf_addr !== 5'd13)  begin n_fail++; $display("FAIL full_pop_c got %0d want 13", rf_addr); end
    n_checks++; if (rf_data !== 32'hA3) begin n_fail++; $display("FAIL full_pop_c_data got %h want a3", rf_data); end
    n_checks++; if (pending !== 1'b0)   begin n_fail++; $display("FAIL full_empty got %b want 0", pending); end
  endtask

  task automatic test_addr0();
    wb_we = 1; wb_addr = 5'd0; wb_data = 32'hFF;
    tick();
    wb_we = 0;
    n_checks++; if (rf_we !== 1'b0)    begin n_fail++; $display("FAIL a0_wb_rf_we got %b want 0", rf_we); end
    n_checks++; if (rf_addr !== 5'd13) begin n_fail++; $display("FAIL a0_wb_hold got %0d want 13", rf_addr); end
    aux_valid = 1; aux_addr = 5'd0; aux_data = 32'h55; chk_addr = 5'd0;
    tick();
    aux_valid = 0;
    n_checks++; if (pending !== 1'b1) begin n_fail++; $display("FAIL a0_pending got %b want 1", pending); end
    n_checks++; if (chk_hit !== 1'b0) begin n_fail++; $display("FAIL a0_chk got %b want 0", chk_hit); end
    tick();
    n_checks++; if (pending !== 1'b0) begin n_fail++; $display("FAIL a0_popped got %b want 0", pending); end
    n_checks++; if (rf_we !== 1'b0)   begin n_fail++; $display("FAIL a0_aux_rf_we got %b want 0", rf_we); end
  endtask

  task automatic test_reset_mid();
    wb_we = 1; wb_addr = 5'd20; wb_data = 32'h220;
    aux_valid = 1; aux_addr = 5'd21; aux_data = 32'h221; chk_addr = 5'd21;
    tick();
    aux_addr = 5'd22; aux_data = 32'h222;
    tick();
    aux_valid = 0;
    n_checks++; if (rf_we !== 1'b1 || pending !== 1'b1) begin n_fail++; $display("FAIL rmid_setup got we=%b pend=%b want 1 1", rf_we, pending); end
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (rf_we !== 1'b0)     begin n_fail++; $display("FAIL rmid_rf_we got %b want 0", rf_we); end
    n_checks++; if (pending !== 1'b0)   begin n_fail++; $display("FAIL rmid_pending got %b want 0", pending); end
    n_checks++; if (aux_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_aux_ready got %b want 1", aux_ready); end
    n_checks++; if (stall_wb !== 1'b0)  begin n_fail++; $display("FAIL rmid_stall got %b want 0", stall_wb); end
    n_checks++; if (rf_addr !== 5'd0)   begin n_fail++; $display("FAIL rmid_rf_addr got %0d want 0", rf_addr); end
    n_checks++; if (chk_hit !== 1'b0)   begin n_fail++; $display("FAIL rmid_chk got %b want 0", chk_hit); end
    wb_we = 0;
    @(negedge clock); reset_n = 1'b1;
    tick();
    n_checks++; if (rf_we !== 1'b0)   begin n_fail++; $display("FAIL rmid_stale1 got %b want 0", rf_we); end
    n_checks++; if (pending !== 1'b0) begin n_fail++; $display("FAIL rmid_stale_pend got %b want 0", pending); end
    tick();
    n_checks++; if (rf_we !== 1'b0)   begin n_fail++; $display("FAIL rmid_stale2 got %b want 0", rf_we); end
  endtask

  initial begin
    test_reset();
    test_writeback();
    test_aux_idle();
    test_starvation();
    test_full();
    test_addr0();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Write-port arbiter for the pipeline register file. It shares the single register-file write port between two writers: the in-order writeback stage and an auxiliary long-latency writer, such as a multi-cycle multiply/divide unit. Auxiliary writes are buffered in a small FIFO. Writeback has priority, and a starvation guard eventually stalls writeback so buffered writes drain. A hazard-check port lets decode detect reads of registers whose writes are still pending.

## Interface
Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register address width
- FIFO_DEPTH, 2, auxiliary buffer entries (power of 2, ≥2)
- MAX_WAIT, 4, cycles a nonempty FIFO may go unserved before writeback is stalled (≥1)

Ports:
- clock  in  1  single clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- wb_we  in  1  writeback write request
- wb_addr  in  ADDR_W  writeback destination register
- wb_data  in  DATA_W  writeback data
- aux_valid  in  1  auxiliary write offered
- aux_ready  out  1  auxiliary write accepted this cycle when aux_valid=1
- aux_addr  in  ADDR_W  auxiliary destination register
- aux_data  in  DATA_W  auxiliary data
- stall_wb  out  1  writeback not granted this cycle; upstream holds wb_* stable
- rf_we  out  1  to register-file RegWrite
- rf_addr  out  ADDR_W  to register-file write_reg
- rf_data  out  DATA_W  to register-file write_data
- pending  out  1  FIFO nonempty
- chk_addr  in  ADDR_W  decode source register to check
- chk_hit  out  1  chk_addr has a write pending in the FIFO or the output register

## Operation
- FIFO holds {addr, data} entries in order.
  - aux_ready = !full, combinational from registered state; no full-cycle bypass.
  - Push occurs when aux_valid && aux_ready.
- wait_cnt:
  - Clears to 0 when the FIFO is empty or on a pop.
  - Otherwise increments by 1 per cycle, saturating at MAX_WAIT.
- starve = pending && (wait_cnt == MAX_WAIT). stall_wb = starve, independent of wb_we.
- Grant priority, evaluated each cycle:
  - starve: pop FIFO head.
  - else wb_we: grant writeback.
  - else pending: pop FIFO head.
  - else: idle.
- Output register on each edge:
  - Granted source with address ≠ 0: rf_we←1, and rf_addr/rf_data←that source.
  - Granted source with address 0: write is consumed (popped or granted) but rf_we←0.
  - Idle: rf_we←0; rf_addr/rf_data hold.
- An entry pushed at edge k becomes eligible for pop in the cycle after edge k; there is no same-cycle push-to-grant bypass.
- Push and pop in the same cycle are both performed; occupancy is unchanged.
- chk_hit is combinational:
  - 1 if chk_addr ≠ 0 and it matches any valid FIFO entry, or matches rf_addr with rf_we=1.
  - 0 for chk_addr = 0.
- No reordering between sources: same-address ordering is decode's responsibility via chk_hit.
- Reset (async, any time): clears FIFO pointers/occupancy, wait_cnt, rf_we, rf_addr, and rf_data to 0. Pending entries are discarded.
  - Outputs while reset_n = 0 and after release: rf_we=0, rf_addr=0, rf_data=0, pending=0, stall_wb=0, aux_ready=1, chk_hit=0.

## Timing
- Writeback: wb_we sampled at edge k → rf_we=1 during cycle k..k+1 → register file written at edge k+1.
- Auxiliary, idle writeback: push at edge k → pop at edge k+1 → rf_we=1 after k+1 → register file written at edge k+2.
- Starvation, writeback continuously busy: with push at edge k, stall_wb rises after edge k+MAX_WAIT. The pop occurs at the next edge, and stall_wb falls after that edge if the FIFO is empty.
- Worst-case auxiliary latency, push to rf_we: MAX_WAIT+1 cycles per entry ahead, plus its own.
- Max sustained write rate: one per cycle.
- No combinational path from aux_valid or wb_we to aux_ready or stall_wb.

## Test plan
- Reset mid-stream: 2 entries pending, rf_we=1, then reset_n=0 asynchronously → immediately rf_we=0, pending=0, aux_ready=1, stall_wb=0. After release, no stale write appears.
- Writeback path: wb_we=1, wb_addr=5, wb_data=0xDEADBEEF at edge k → after k, rf_we=1, rf_addr=5, rf_data=0xDEADBEEF. Next cycle rf_we=0 if wb_we=0.
- Auxiliary idle path: push addr 7, data 0x00001234 at edge k, wb_we=0 → pending=1 and chk_addr=7 gives chk_hit=1 after k. After k+1, rf_we=1, rf_addr=7, pending=0.
- Starvation with MAX_WAIT=4: wb_we=1 every cycle (addrs 1..), push addr 9 at edge k → stall_wb=1 after k+4. At edge k+5, rf_addr=9, rf_data=aux data; stall_wb=0 after; held writeback is granted at edge k+6.
- Full FIFO: wb busy, push 2 entries → aux_ready=0; a third aux_valid is held and not accepted. After the first pop, aux_ready=1 and the third entry is accepted in order.
- Address 0: wb_we with wb_addr=0 → rf_we stays 0. An auxiliary push to addr 0 is popped, pending returns to 0, rf_we=0, and chk_addr=0 gives chk_hit=0.
